packet_handler_hls_deadlock_report_ctrl: RTL and testbench

- Central sequencer for the per-process deadlock detect units. Watches their dl_detect outputs and confirms a persistent deadlock.
- Picks one origin process and launches a report token from it. Traces the token around the dependence cycle, then clears it.
- Presents the origin, the set of participating processes, the trace length and a timeout flag on a valid/ready report port.
- Sits at the top of the deadlock-detection fabric: one instance per dataflow region, fanning out to all PROC_NUM detect units.

---
 rtl/packet_handler_hls_dl_pkg.sv | 22 ++
 rtl/packet_handler_hls_dl_prio_enc.sv | 27 ++
 rtl/packet_handler_hls_deadlock_report_ctrl.sv | 151 +++++++++++++++
 tb/tb_packet_handler_hls_deadlock_report_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/packet_handler_hls_dl_pkg.sv
// Shared definitions for the deadlock-report controller slice.
//   dl_state_t    : controller state encoding
//   DL_CNT_W_DEF  : default width of the trace cycle counter
//   dl_id_w()     : index width for N processes (clog2, minimum 1)
package packet_handler_hls_dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_TRACE   = 3'd3,
    ST_REPORT  = 3'd4,
    ST_DONE    = 3'd5
  } dl_state_t;

  localparam int DL_CNT_W_DEF = 16;

  function automatic int dl_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packet_handler_hls_dl_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the deadlock origin.
//   vec   : request vector, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when vec is empty)
//   valid : at least one bit of vec is set
module packet_handler_hls_dl_prio_enc
  import packet_handler_hls_dl_pkg::*;
#(
  parameter int N = 4,
  parameter int W = dl_id_w(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/packet_handler_hls_deadlock_report_ctrl.sv
// Central sequencer for the per-process deadlock detect units.
// Confirms a persistent deadlock, launches a report token from one origin,
// traces it around the dependence cycle and presents the result on a
// valid/ready report port.
//   clock, reset     : clock and synchronous active-low reset
//   dl_detect_vec    : dl_detect_out of each detect unit
//   token_vis_vec    : per process, OR of that unit's token_in_vec
//   dl_detect_all    : registered broadcast dl_detect_in to all units
//   origin_vec       : one-hot origin pulse (LAUNCH only)
//   token_clear      : broadcast token clear (trace end or abort)
//   busy             : controller not idle
//   report_*         : report handshake and payload
//   clear_req        : host re-arm request, returns to IDLE
module packet_handler_hls_deadlock_report_ctrl
  import packet_handler_hls_dl_pkg::*;
#(
  parameter  int PROC_NUM       = 4,
  parameter  int CONFIRM_CYCLES = 4,
  parameter  int MAX_TRACE      = 1024,
  parameter  int CNT_W          = DL_CNT_W_DEF,
  localparam int ID_W           = dl_id_w(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_vis_vec,
  output logic                dl_detect_all,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                busy,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [ID_W-1:0]     report_origin,
  output logic [PROC_NUM-1:0] report_mask,
  output logic [CNT_W-1:0]    report_cycles,
  output logic                report_timeout,
  input  logic                clear_req
);

  localparam int CONF_W = dl_id_w(CONFIRM_CYCLES + 1);

  dl_state_t           state_q, state_d;
  logic [CONF_W-1:0]   confirm_cnt_q;
  logic [ID_W-1:0]     origin_q;
  logic [PROC_NUM-1:0] mask_q;
  logic [CNT_W-1:0]    trace_cnt_q;
  logic                timeout_q;
  logic                dl_all_q;

  logic [ID_W-1:0]     enc_idx;
  logic                enc_valid;
  logic                origin_returned;
  logic                trace_at_max;

  packet_handler_hls_dl_prio_enc #(
    .N (PROC_NUM),
    .W (ID_W)
  ) u_prio_enc (
    .vec   (dl_detect_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign origin_returned = dl_detect_vec[origin_q];
  assign trace_at_max    = (trace_cnt_q == CNT_W'(MAX_TRACE - 1));

  always_comb begin
    state_d     = state_q;
    token_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) state_d = (CONFIRM_CYCLES == 1) ? ST_LAUNCH : ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (!(|dl_detect_vec))                                state_d = ST_IDLE;
        else if (confirm_cnt_q == CONF_W'(CONFIRM_CYCLES - 1)) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_TRACE;
      ST_TRACE: begin
        if (origin_returned || trace_at_max) begin
          token_clear = 1'b1;
          state_d     = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (report_ready) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // Host abort overrides every transition; a token in flight is cleared.
    if (clear_req && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      if (state_q == ST_TRACE) token_clear = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      confirm_cnt_q <= '0;
      origin_q      <= '0;
      mask_q        <= '0;
      trace_cnt_q   <= '0;
      timeout_q     <= 1'b0;
      dl_all_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Registered from the next state so it tracks LAUNCH..DONE exactly.
      dl_all_q <= (state_d inside {ST_LAUNCH, ST_TRACE, ST_REPORT, ST_DONE});
      unique case (state_q)
        ST_IDLE: begin
          if (enc_valid) begin
            origin_q      <= enc_idx;
            confirm_cnt_q <= CONF_W'(1);
          end
        end
        ST_CONFIRM: begin
          if (|dl_detect_vec) confirm_cnt_q <= confirm_cnt_q + 1'b1;
        end
        ST_LAUNCH: begin
          trace_cnt_q <= '0;
          timeout_q   <= 1'b0;
          mask_q      <= PROC_NUM'(1) << origin_q;
        end
        ST_TRACE: begin
          if (!clear_req) begin
            mask_q <= mask_q | token_vis_vec;
            // The exit cycle increments too, so report_cycles = count + 1.
            if (trace_cnt_q != '1) trace_cnt_q <= trace_cnt_q + 1'b1;
            if (state_d == ST_REPORT) timeout_q <= !origin_returned;
          end
        end
        default: ;
      endcase
    end
  end

  assign dl_detect_all  = dl_all_q;
  assign busy           = (state_q != ST_IDLE);
  assign report_valid   = (state_q == ST_REPORT);
  assign origin_vec     = (state_q == ST_LAUNCH) ? (PROC_NUM'(1) << origin_q) : '0;
  assign report_origin  = origin_q;
  assign report_mask    = mask_q;
  assign report_cycles  = trace_cnt_q;
  assign report_timeout = timeout_q;

endmodule

// File: tb/tb_packet_handler_hls_deadlock_report_ctrl.sv
// Directed self-checking bench for packet_handler_hls_deadlock_report_ctrl
// (PROC_NUM=4, CONFIRM_CYCLES=4, MAX_TRACE=8, CNT_W=16).
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge.
module tb_packet_handler_hls_deadlock_report_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  dl_detect_vec;
  logic [3:0]  token_vis_vec;
  logic        dl_detect_all;
  logic [3:0]  origin_vec;
  logic        token_clear;
  logic        busy;
  logic        report_valid;
  logic        report_ready;
  logic [1:0]  report_origin;
  logic [3:0]  report_mask;
  logic [15:0] report_cycles;
  logic        report_timeout;
  logic        clear_req;

  int checks = 0;
  int errors = 0;

  // Event counters sampled at the rising edge (values of the ending cycle).
  int pulse_cnt = 0;
  int tc_cnt    = 0;
  int xfer_cnt  = 0;

  packet_handler_hls_deadlock_report_ctrl #(
    .PROC_NUM       (4),
    .CONFIRM_CYCLES (4),
    .MAX_TRACE      (8),
    .CNT_W          (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dl_detect_vec  (dl_detect_vec),
    .token_vis_vec  (token_vis_vec),
    .dl_detect_all  (dl_detect_all),
    .origin_vec     (origin_vec),
    .token_clear    (token_clear),
    .busy           (busy),
    .report_valid   (report_valid),
    .report_ready   (report_ready),
    .report_origin  (report_origin),
    .report_mask    (report_mask),
    .report_cycles  (report_cycles),
    .report_timeout (report_timeout),
    .clear_req      (clear_req)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (origin_vec != 4'b0)           pulse_cnt <= pulse_cnt + 1;
    if (token_clear)                  tc_cnt    <= tc_cnt + 1;
    if (report_valid && report_ready) xfer_cnt  <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, dl_detect_all, origin_vec, token_clear, busy, report_valid,
            report_origin, report_mask, report_cycles, report_timeout};
  endfunction

  function automatic logic [31:0] payload();
    return {9'd0, report_origin, report_mask, report_cycles, report_timeout};
  endfunction

  // Hold vec for four cycles, then leave the caller in the LAUNCH cycle.
  task automatic arm(input logic [3:0] vec);
    for (int i = 0; i < 4; i++) begin
      cyc(); dl_detect_vec = vec; token_vis_vec = 4'b0; settle();
    end
    cyc(); dl_detect_vec = 4'b0; settle();
  endtask

  initial begin
    int base_pulse, base_tc, base_xfer;
    logic seen_busy, seen_all;

    reset = 1'b0; dl_detect_vec = '0; token_vis_vec = '0;
    report_ready = 1'b0; clear_req = 1'b0;
    cyc(); cyc(); settle();
    check("reset_outputs", all_outs(), 32'd0);
    cyc(); reset = 1'b1; settle();

    // No deadlock for 100 cycles.
    base_pulse = pulse_cnt; seen_busy = 1'b0; seen_all = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(); dl_detect_vec = 4'b0; settle();
      seen_busy |= busy; seen_all |= dl_detect_all;
    end
    check("idle_busy", 32'(seen_busy), 32'd0);
    check("idle_dl_all", 32'(seen_all), 32'd0);
    check("idle_pulses", 32'(pulse_cnt - base_pulse), 32'd0);

    // Glitch: three cycles of detection then gone.
    base_pulse = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      cyc(); dl_detect_vec = 4'b0100; settle();
    end
    check("glitch_confirm_busy", 32'(busy), 32'd1);
    check("glitch_confirm_dl_all", 32'(dl_detect_all), 32'd0);
    cyc(); dl_detect_vec = 4'b0; settle();
    cyc(); settle();
    check("glitch_back_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin cyc(); settle(); end
    check("glitch_no_pulse", 32'(pulse_cnt - base_pulse), 32'd0);

    // Normal trace, origin 1, return on the 5th TRACE cycle.
    report_ready = 1'b1;
    base_pulse = pulse_cnt; base_tc = tc_cnt;
    arm(4'b0110);
    check("norm_origin_vec", 32'(origin_vec), 32'h2);
    check("norm_launch_dl_all", 32'(dl_detect_all), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      token_vis_vec = (i == 1) ? 4'b0100 : (i == 2) ? 4'b1000 : 4'b0000;
      dl_detect_vec = (i == 5) ? 4'b0010 : 4'b0000;
      settle();
      check($sformatf("norm_token_clear_c%0d", i), 32'(token_clear), 32'(i == 5));
    end
    cyc(); dl_detect_vec = 4'b0; token_vis_vec = 4'b0; settle();
    check("norm_report_valid", 32'(report_valid), 32'd1);
    check("norm_payload", payload(), {9'd0, 2'd1, 4'b1110, 16'd5, 1'b0});
    cyc(); settle();
    check("norm_done_valid", 32'(report_valid), 32'd0);
    check("norm_done_busy_all", {30'd0, busy, dl_detect_all}, 32'd3);
    check("norm_done_payload", payload(), {9'd0, 2'd1, 4'b1110, 16'd5, 1'b0});
    check("norm_pulses", 32'(pulse_cnt - base_pulse), 32'd1);
    check("norm_clears", 32'(tc_cnt - base_tc), 32'd1);
    cyc(); clear_req = 1'b1; settle();
    cyc(); clear_req = 1'b0; settle();
    check("norm_rearm_idle", {30'd0, busy, dl_detect_all}, 32'd0);

    // Timeout with backpressure: origin 0 never returns.
    report_ready = 1'b0;
    arm(4'b0001);
    check("to_origin_vec", 32'(origin_vec), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      cyc(); token_vis_vec = (i == 2) ? 4'b0100 : 4'b0000; settle();
      check($sformatf("to_token_clear_c%0d", i), 32'(token_clear), 32'(i == 8));
    end
    base_xfer = xfer_cnt;
    for (int k = 0; k < 10; k++) begin
      cyc(); token_vis_vec = 4'b0; settle();
      check($sformatf("bp_valid_%0d", k), 32'(report_valid), 32'd1);
      check($sformatf("bp_payload_%0d", k), payload(), {9'd0, 2'd0, 4'b0101, 16'd8, 1'b1});
    end
    cyc(); report_ready = 1'b1; settle();
    check("bp_hs_valid", 32'(report_valid), 32'd1);
    cyc(); report_ready = 1'b0; settle();
    check("bp_done_valid", 32'(report_valid), 32'd0);
    check("bp_done_busy_all", {30'd0, busy, dl_detect_all}, 32'd3);
    check("bp_done_payload", payload(), {9'd0, 2'd0, 4'b0101, 16'd8, 1'b1});
    check("bp_transfers", 32'(xfer_cnt - base_xfer), 32'd1);
    cyc(); clear_req = 1'b1; settle();
    cyc(); clear_req = 1'b0; settle();

    // Abort during TRACE.
    arm(4'b1000);
    check("abort_origin_vec", 32'(origin_vec), 32'h8);
    cyc(); settle();
    cyc(); clear_req = 1'b1; settle();
    check("abort_token_clear", 32'(token_clear), 32'd1);
    cyc(); clear_req = 1'b0; settle();
    check("abort_idle", {30'd0, busy, dl_detect_all}, 32'd0);
    check("abort_no_clear_after", 32'(token_clear), 32'd0);

    // Reset while in REPORT: immediate return, origin 0.
    arm(4'b0001);
    cyc(); dl_detect_vec = 4'b0001; settle();
    check("rst_return_clear", 32'(token_clear), 32'd1);
    cyc(); dl_detect_vec = 4'b0; settle();
    check("rst_report_payload", payload(), {9'd0, 2'd0, 4'b0001, 16'd1, 1'b0});
    check("rst_report_valid", 32'(report_valid), 32'd1);
    base_tc = tc_cnt;
    cyc(); reset = 1'b0; settle();
    cyc(); settle();
    check("rst_all_zero", all_outs(), 32'd0);
    cyc(); reset = 1'b1; settle();
    check("rst_no_token_clear", 32'(tc_cnt - base_tc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
